// File: rtl/branch_comparer_unit.sv
// Purpose: ID-stage branch resolution - forwarded operand compare, condition eval, registered decision.
// Latency: zero/o_taken combinational (0 cycles); o_taken_q/o_valid_q and counters 1 cycle.
// Backpressure: none; every cycle is evaluated, i_branch acts as the valid qualifier.
//
// Optional feature macro: BRANCH_CMP_STATS_EN (branch evaluated/taken statistics counters).
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_rs, i_rt              register-file operands
//   i_ex_data, i_mem_data   forwarded values from EX / MEM
//   i_fwd_rs, i_fwd_rt      operand source select (00 rf, 01 EX, 10 MEM, 11 rf)
//   i_branch, i_br_op       branch valid and condition select
//   i_stats_clr             synchronous counter clear (priority over increment)
//   zero, o_taken           combinational equality and branch decision
//   o_taken_q, o_valid_q    registered decision / valid
//   o_eval_cnt, o_taken_cnt saturating statistics (tied to 0 without BRANCH_CMP_STATS_EN)
module branch_comparer_unit #(
  parameter int RBITS   = 32,
  parameter int CNTBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [RBITS-1:0]   i_rs,
  input  logic [RBITS-1:0]   i_rt,
  input  logic [RBITS-1:0]   i_ex_data,
  input  logic [RBITS-1:0]   i_mem_data,
  input  logic [1:0]         i_fwd_rs,
  input  logic [1:0]         i_fwd_rt,
  input  logic               i_branch,
  input  logic [2:0]         i_br_op,
  input  logic               i_stats_clr,
  output logic               zero,
  output logic               o_taken,
  output logic               o_taken_q,
  output logic               o_valid_q,
  output logic [CNTBITS-1:0] o_eval_cnt,
  output logic [CNTBITS-1:0] o_taken_cnt
);

  logic [RBITS-1:0] rs_eff;
  logic [RBITS-1:0] rt_eff;
  logic             rs_neg;
  logic             rs_is_zero;
  logic             cond;

  // Select code 11 is reserved and falls back to the register file.
  always_comb begin
    rs_eff = i_rs;
    case (i_fwd_rs)
      2'b01:   rs_eff = i_ex_data;
      2'b10:   rs_eff = i_mem_data;
      default: rs_eff = i_rs;
    endcase
  end

  always_comb begin
    rt_eff = i_rt;
    case (i_fwd_rt)
      2'b01:   rt_eff = i_ex_data;
      2'b10:   rt_eff = i_mem_data;
      default: rt_eff = i_rt;
    endcase
  end

  assign zero       = (rs_eff == rt_eff);
  // Sign tests against zero need only the MSB and an all-zero detect.
  assign rs_neg     = rs_eff[RBITS-1];
  assign rs_is_zero = (rs_eff == '0);

  always_comb begin
    cond = 1'b0;
    case (i_br_op)
      3'b000:  cond = zero;                   // BEQ
      3'b001:  cond = ~zero;                  // BNE
      3'b010:  cond = rs_neg | rs_is_zero;    // BLEZ
      3'b011:  cond = ~rs_neg & ~rs_is_zero;  // BGTZ
      3'b100:  cond = rs_neg;                 // BLTZ
      3'b101:  cond = ~rs_neg;                // BGEZ
      default: cond = 1'b0;
    endcase
  end

  assign o_taken = i_branch & cond;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_taken_q <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      o_taken_q <= o_taken;
      o_valid_q <= i_branch;
    end
  end

`ifdef BRANCH_CMP_STATS_EN
  logic [CNTBITS-1:0] eval_cnt;
  logic [CNTBITS-1:0] taken_cnt;

  // Counters stick at all-ones rather than wrapping; clear beats increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else if (i_stats_clr) begin
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else if (i_branch) begin
      if (eval_cnt != '1) begin
        eval_cnt <= eval_cnt + 1'b1;
      end
      if (o_taken && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

  assign o_eval_cnt  = eval_cnt;
  assign o_taken_cnt = taken_cnt;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = i_stats_clr;
  assign o_eval_cnt       = '0;
  assign o_taken_cnt      = '0;
`endif

endmodule

// File: tb/tb_branch_comparer_unit.sv
// Purpose: self-checking bench for branch_comparer_unit (directed steps plus random traffic).
// Latency: checks combinational outputs same cycle, registered outputs 1 cycle after the edge.
// Backpressure: not applicable; the bench drives every input each step.
module tb_branch_comparer_unit;

  localparam int RBITS   = 32;
  localparam int CNTBITS = 4;
  localparam int CMAX    = (1 << CNTBITS) - 1;

  logic               i_clk;
  logic               i_rst_n;
  logic [RBITS-1:0]   i_rs, i_rt, i_ex_data, i_mem_data;
  logic [1:0]         i_fwd_rs, i_fwd_rt;
  logic               i_branch;
  logic [2:0]         i_br_op;
  logic               i_stats_clr;
  logic               zero, o_taken, o_taken_q, o_valid_q;
  logic [CNTBITS-1:0] o_eval_cnt, o_taken_cnt;

  int tests = 0;
  int fails = 0;

  // Reference state for the clocked outputs.
  logic m_taken_q, m_valid_q;
  int   m_eval, m_taken;

  branch_comparer_unit #(.RBITS(RBITS), .CNTBITS(CNTBITS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rs(i_rs), .i_rt(i_rt), .i_ex_data(i_ex_data), .i_mem_data(i_mem_data),
    .i_fwd_rs(i_fwd_rs), .i_fwd_rt(i_fwd_rt),
    .i_branch(i_branch), .i_br_op(i_br_op), .i_stats_clr(i_stats_clr),
    .zero(zero), .o_taken(o_taken), .o_taken_q(o_taken_q), .o_valid_q(o_valid_q),
    .o_eval_cnt(o_eval_cnt), .o_taken_cnt(o_taken_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [RBITS-1:0] pick(input logic [1:0] sel, input logic [RBITS-1:0] rf,
                                            input logic [RBITS-1:0] ex, input logic [RBITS-1:0] mem);
    if (sel == 2'd1) return ex;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic ref_zero();
    return pick(i_fwd_rs, i_rs, i_ex_data, i_mem_data) == pick(i_fwd_rt, i_rt, i_ex_data, i_mem_data);
  endfunction

  function automatic logic ref_taken();
    logic [RBITS-1:0]        a, b;
    logic signed [RBITS-1:0] s;
    logic                    t;
    a = pick(i_fwd_rs, i_rs, i_ex_data, i_mem_data);
    b = pick(i_fwd_rt, i_rt, i_ex_data, i_mem_data);
    s = a;
    case (i_br_op)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd2:    t = (s <= 0);
      3'd3:    t = (s > 0);
      3'd4:    t = (s < 0);
      3'd5:    t = (s >= 0);
      default: t = 1'b0;
    endcase
    return i_branch && t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [RBITS-1:0] rs, input logic [RBITS-1:0] rt,
                       input logic [RBITS-1:0] ex, input logic [RBITS-1:0] mem,
                       input logic [1:0] frs, input logic [1:0] frt,
                       input logic br, input logic [2:0] op, input logic clr);
    i_rs = rs; i_rt = rt; i_ex_data = ex; i_mem_data = mem;
    i_fwd_rs = frs; i_fwd_rt = frt; i_branch = br; i_br_op = op; i_stats_clr = clr;
    #1;
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".zero"}, 64'(zero), 64'(ref_zero()));
    check({tag, ".taken"}, 64'(o_taken), 64'(ref_taken()));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".taken_q"}, 64'(o_taken_q), 64'(m_taken_q));
    check({tag, ".valid_q"}, 64'(o_valid_q), 64'(m_valid_q));
    check({tag, ".eval_cnt"}, 64'(o_eval_cnt), 64'(m_eval));
    check({tag, ".taken_cnt"}, 64'(o_taken_cnt), 64'(m_taken));
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick(input string tag);
    logic t;
    t = ref_taken();
    m_taken_q = t;
    m_valid_q = i_branch;
`ifdef BRANCH_CMP_STATS_EN
    if (i_stats_clr) begin
      m_eval = 0; m_taken = 0;
    end else if (i_branch) begin
      m_eval = (m_eval + 1 > CMAX) ? CMAX : m_eval + 1;
      if (t) m_taken = (m_taken + 1 > CMAX) ? CMAX : m_taken + 1;
    end
`endif
    @(posedge i_clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [RBITS-1:0] pool [6];
    logic [RBITS-1:0] v [4];

    m_taken_q = 1'b0; m_valid_q = 1'b0; m_eval = 0; m_taken = 0;
    i_rst_n = 1'b0;
    drive(32'd1, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
    check_regs("reset");
    check("reset.zero", 64'(zero), 64'(0));
    // Combinational outputs follow inputs while held in reset.
    drive(32'd1, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0);
    check("reset.comb_taken", 64'(o_taken), 64'(1));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Equality, same cycle.
    drive(32'd1, 32'd2, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
    check("eq.diff", 64'(zero), 64'(0));
    drive(32'd1, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
    check("eq.same", 64'(zero), 64'(1));
    check("eq.nobranch", 64'(o_taken), 64'(0));

    // BNE then registered copy.
    drive(32'd5, 32'd5, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd1, 1'b1);
    check("bne.equal", 64'(o_taken), 64'(0));
    drive(32'd5, 32'd6, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd1, 1'b1);
    check("bne.diff", 64'(o_taken), 64'(1));
    tick("bne");
    check("bne.taken_q", 64'(o_taken_q), 64'(1));
    check("bne.valid_q", 64'(o_valid_q), 64'(1));

    // Sign-based conditions at the negative boundary and at zero.
    drive(32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd4, 1'b0);
    check("bltz.min", 64'(o_taken), 64'(1));
    drive(32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd2, 1'b0);
    check("blez.min", 64'(o_taken), 64'(1));
    drive(32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd5, 1'b0);
    check("bgez.min", 64'(o_taken), 64'(0));
    drive(32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd3, 1'b0);
    check("bgtz.min", 64'(o_taken), 64'(0));
    drive(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd2, 1'b0);
    check("blez.zero", 64'(o_taken), 64'(1));
    drive(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd5, 1'b0);
    check("bgez.zero", 64'(o_taken), 64'(1));
    drive(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd3, 1'b0);
    check("bgtz.zero", 64'(o_taken), 64'(0));
    drive(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd6, 1'b0);
    check("op6.never", 64'(o_taken), 64'(0));
    drive(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd7, 1'b0);
    check("op7.never", 64'(o_taken), 64'(0));

    // Forwarding selects.
    drive(32'd3, 32'd7, 32'd7, 32'd9, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0);
    check("fwd.ex", 64'(zero), 64'(1));
    drive(32'd3, 32'd7, 32'd7, 32'd9, 2'b11, 2'b00, 1'b0, 3'd0, 1'b0);
    check("fwd.rsv", 64'(zero), 64'(0));
    drive(32'd3, 32'd9, 32'd7, 32'd9, 2'b10, 2'b00, 1'b0, 3'd0, 1'b0);
    check("fwd.mem", 64'(zero), 64'(1));
    drive(32'd3, 32'd1, 32'd3, 32'd9, 2'b00, 2'b01, 1'b1, 3'd0, 1'b0);
    check("fwd.rt_ex", 64'(o_taken), 64'(1));

    // Statistics: clear, 4 branches with 3 taken, then clear while branching.
    drive(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1);
    tick("clr0");
    v[0] = 32'd1; v[1] = 32'd2; v[2] = 32'd1; v[3] = 32'd1;
    for (int k = 0; k < 4; k++) begin
      drive(v[k], 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0);
      tick("count");
    end
`ifdef BRANCH_CMP_STATS_EN
    check("count.eval4", 64'(o_eval_cnt), 64'(4));
    check("count.taken3", 64'(o_taken_cnt), 64'(3));
`endif
    drive(32'd1, 32'd1, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b1);
    tick("clr_prio");
    // Saturation: run more taken branches than the counter can hold.
    for (int k = 0; k < CMAX + 4; k++) begin
      drive(32'd4, 32'd4, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0);
      tick("sat");
    end

    // Randomized traffic with boundary-heavy operand pool.
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h8000_0000;
    pool[3] = 32'h7fff_ffff; pool[4] = 32'hffff_ffff; pool[5] = 32'h5;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 4; k++) begin
        v[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : pool[$urandom_range(0, 5)];
      end
      drive(v[0], v[1], v[2], v[3], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 15) == 0));
      check_comb("rand");
      tick("rand");
    end

    // Asynchronous reset between edges with a taken decision registered.
    drive(32'd5, 32'd6, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0);
    tick("pre_rst");
    check("pre_rst.taken_q", 64'(o_taken_q), 64'(1));
    #2;
    i_rst_n = 1'b0;
    #1;
    m_taken_q = 1'b0; m_valid_q = 1'b0; m_eval = 0; m_taken = 0;
    check_regs("async_rst");
    check("async_rst.comb", 64'(o_taken), 64'(1));
    #1;
    i_rst_n = 1'b1;
    tick("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
